multdiv_issue: RTL and testbench

Issue and writeback controller for the iterative multiply/divide unit. It sits between the execute stage and the unit:
- accepts one mult or div request from the pipeline;
- latches and holds the operands stable;
- pulses the unit's start control;
- stalls the pipeline until the unit signals ready;
- returns exactly one writeback, either to the destination register or, on exception, an error code to $rstatus.

---
 rtl/multdiv_issue.sv | 166 ++++++++++++++++
 tb/tb_multdiv_issue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue.sv
// Issue/writeback controller for the iterative multiply/divide unit: latches a
// request, pulses the unit's start, stalls the pipeline and returns one writeback.
module multdiv_issue #(
    parameter int TIMEOUT       = 40,
    parameter int MULT_EXC_CODE = 4,
    parameter int DIV_EXC_CODE  = 5,
    parameter int RSTATUS_REG   = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [4:0]       RSTAT_IDX = 5'(RSTATUS_REG);
    localparam logic [31:0]      MULT_CODE = 32'(MULT_EXC_CODE);
    localparam logic [31:0]      DIV_CODE  = 32'(DIV_EXC_CODE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_MASK  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              op_div_r;
    logic [4:0]        rd_r;
    logic [31:0]       opa_r, opb_r;
    logic              ctrl_mult_r, ctrl_div_r, wb_valid_r;
    logic [4:0]        wb_rd_r;
    logic [31:0]       wb_data_r;

    logic              accept_s, done_s, exc_s;
    logic [31:0]       res_s;
    logic              ctrl_mult_nxt_s, ctrl_div_nxt_s, wb_valid_nxt_s;
    logic [4:0]        wb_rd_nxt_s;
    logic [31:0]       wb_data_nxt_s;

    // Next-state, completion capture and next values of the registered outputs.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        accept_s        = 1'b0;
        done_s          = 1'b0;
        exc_s           = 1'b0;
        res_s           = 32'd0;
        ctrl_mult_nxt_s = 1'b0;
        ctrl_div_nxt_s  = 1'b0;
        wb_valid_nxt_s  = 1'b0;
        wb_rd_nxt_s     = 5'd0;
        wb_data_nxt_s   = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (start_mult || start_div) begin
                    accept_s        = 1'b1;
                    ctrl_mult_nxt_s = start_mult;
                    ctrl_div_nxt_s  = ~start_mult;
                    state_nxt_s     = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_MASK;
            // Ready may still be stale from the previous operation here.
            ST_MASK: begin
                cnt_nxt_s   = '0;
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (md_ready) begin
                    done_s = 1'b1;
                    exc_s  = md_exception;
                    res_s  = md_result;
                end else if (cnt_r == CNT_LAST) begin
                    done_s = 1'b1;
                    exc_s  = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WB:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase

        if (done_s) begin
            state_nxt_s = ST_WB;
            if (exc_s) begin
                wb_valid_nxt_s = 1'b1;
                wb_rd_nxt_s    = RSTAT_IDX;
                wb_data_nxt_s  = op_div_r ? DIV_CODE : MULT_CODE;
            end else if (rd_r != 5'd0) begin
                wb_valid_nxt_s = 1'b1;
                wb_rd_nxt_s    = rd_r;
                wb_data_nxt_s  = res_s;
            end else begin
                wb_valid_nxt_s = 1'b0;
            end
        end else begin
            wb_valid_nxt_s = 1'b0;
        end
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            op_div_r    <= 1'b0;
            rd_r        <= 5'd0;
            opa_r       <= 32'd0;
            opb_r       <= 32'd0;
            ctrl_mult_r <= 1'b0;
            ctrl_div_r  <= 1'b0;
            wb_valid_r  <= 1'b0;
            wb_rd_r     <= 5'd0;
            wb_data_r   <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ctrl_mult_r <= ctrl_mult_nxt_s;
            ctrl_div_r  <= ctrl_div_nxt_s;
            wb_valid_r  <= wb_valid_nxt_s;
            wb_rd_r     <= wb_rd_nxt_s;
            wb_data_r   <= wb_data_nxt_s;
            if (accept_s) begin
                op_div_r <= ~start_mult;
                rd_r     <= rd_in;
                opa_r    <= operand_a;
                opb_r    <= operand_b;
            end
        end
    end

    // In IDLE the requesting instruction must freeze in its own cycle.
    assign stall = (state_r == ST_IDLE) ? (reset & (start_mult | start_div))
                                        : (state_r != ST_WB);

    assign ctrl_mult    = ctrl_mult_r;
    assign ctrl_div     = ctrl_div_r;
    assign md_operand_a = opa_r;
    assign md_operand_b = opb_r;
    assign wb_valid     = wb_valid_r;
    assign wb_rd        = wb_rd_r;
    assign wb_data      = wb_data_r;

endmodule

// File: tb/tb_multdiv_issue.sv
// Scoreboard bench for multdiv_issue: the bench plays the mult/div unit, predicts
// each writeback from operation semantics and checks cycle-level handshakes.
module tb_multdiv_issue;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0, start_div = 1'b0;
    logic [31:0] operand_a = 32'd0, operand_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic [31:0] md_result = 32'd0;
    logic        md_exception = 1'b0, md_ready = 1'b0;
    logic        ctrl_mult, ctrl_div, stall, wb_valid;
    logic [31:0] md_operand_a, md_operand_b, wb_data;
    logic [4:0]  wb_rd;

    multdiv_issue #(.TIMEOUT(TIMEOUT), .MULT_EXC_CODE(4), .DIV_EXC_CODE(5), .RSTATUS_REG(30)) dut (
        .clock(clock), .reset(reset),
        .start_mult(start_mult), .start_div(start_div),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .md_operand_a(md_operand_a), .md_operand_b(md_operand_b),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wb_t;
    wb_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every writeback strobe must match the oldest prediction.
    always @(negedge clock) begin
        if (reset && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wb_spurious: got wb_valid rd=%0d data=0x%0h, expected none (cycle %0d)",
                         wb_rd, wb_data, cyc);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
                chk("wb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Behavioural model of the unit's arithmetic.
    function automatic void unit_model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] res, output bit exc);
        logic [63:0] p;
        if (is_mult) begin
            p   = {32'd0, a} * {32'd0, b};
            res = p[31:0];
            exc = (p[63:32] != 32'd0);
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            res = a / b;
            exc = 1'b0;
        end
    endfunction

    // One operation: accept in cycle 0, unit ready in cycle k (k >= 3+TIMEOUT
    // means never), optional stale ready in cycles 0..2, optional reset at abort_c.
    task automatic do_op(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int k, input bit stale, input int abort_c);
        logic [31:0] res;
        bit          exc, timed_out;
        int          e_c, t0;
        wb_t         w;
        unit_model(sm, a, b, res, exc);
        timed_out = (k >= 3 + TIMEOUT);
        e_c = timed_out ? 3 + TIMEOUT : k + 1;
        t0 = 0;
        for (int c = 0; c <= e_c; c++) begin
            @(posedge clock);
            #1;
            if (c == 0) begin
                t0 = cyc;
                start_mult = sm;
                start_div  = sd;
                operand_a  = a;
                operand_b  = b;
                rd_in      = rd;
                if (abort_c < 0 && (timed_out || exc || rd != 5'd0)) begin
                    w.rd   = (timed_out || exc) ? 5'd30 : rd;
                    w.data = (timed_out || exc) ? (sm ? 32'd4 : 32'd5) : res;
                    w.cyc  = t0 + e_c;
                    exp_q.push_back(w);
                end
            end else begin
                start_mult = ($urandom_range(0, 3) == 0);
                start_div  = ($urandom_range(0, 3) == 0);
                operand_a  = $urandom;
                operand_b  = $urandom;
                rd_in      = 5'($urandom);
            end
            if (c == k) begin
                md_ready     = 1'b1;
                md_result    = res;
                md_exception = exc;
            end else begin
                md_ready     = (c < 3) ? stale : 1'b0;
                md_result    = $urandom;
                md_exception = 1'($urandom);
            end
            if (c == abort_c) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_stall", 32'(stall), 32'd0);
                chk("rst_ctrl_mult", 32'(ctrl_mult), 32'd0);
                chk("rst_ctrl_div", 32'(ctrl_div), 32'd0);
                chk("rst_wb_valid", 32'(wb_valid), 32'd0);
                chk("rst_operand_a", md_operand_a, 32'd0);
                exp_q.delete();
                start_mult = 1'b0;
                start_div  = 1'b0;
                md_ready   = 1'b0;
                @(negedge clock);
                #1 reset = 1'b1;
                return;
            end
            @(negedge clock);
            chk("stall", 32'(stall), 32'(c < e_c));
            chk("ctrl_mult", 32'(ctrl_mult), 32'(c == 1 && sm));
            chk("ctrl_div", 32'(ctrl_div), 32'(c == 1 && !sm));
            if (c >= 1) begin
                chk("operand_a_hold", md_operand_a, a);
                chk("operand_b_hold", md_operand_b, b);
            end
        end
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        md_ready   = 1'b0;
        @(negedge clock);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("wb_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit          sm, sd;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          sel, k;
        repeat (3) @(negedge clock);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_ctrl_mult", 32'(ctrl_mult), 32'd0);
        chk("reset_ctrl_div", 32'(ctrl_div), 32'd0);
        chk("reset_wb_valid", 32'(wb_valid), 32'd0);
        chk("reset_wb_rd", 32'(wb_rd), 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_operand_a", md_operand_a, 32'd0);
        chk("reset_operand_b", md_operand_b, 32'd0);
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);

        do_op(1'b0, 1'b1, 32'd100, 32'd7, 5'd9, 33, 1'b0, -1);
        do_op(1'b0, 1'b1, 32'd5, 32'd0, 5'd3, 10, 1'b0, -1);
        do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd4, 5, 1'b0, -1);
        do_op(1'b1, 1'b0, 32'd3, 32'd5, 5'd7, 13, 1'b1, -1);
        do_op(1'b1, 1'b1, 32'd2, 32'd3, 5'd0, 6, 1'b1, -1);
        do_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd8, 20, 1'b0, 8);
        do_op(1'b0, 1'b1, 32'd9, 32'd3, 5'd8, 20, 1'b0, 1);
        do_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd8, 4, 1'b1, -1);
        do_op(1'b0, 1'b1, 32'd77, 32'd7, 5'd11, 1000, 1'b0, -1);
        do_op(1'b1, 1'b0, 32'd2, 32'd2, 5'd0, 1000, 1'b1, -1);
        do_op(1'b0, 1'b1, 32'd50, 32'd5, 5'd2, 2 + TIMEOUT, 1'b0, -1);

        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 2);
            sm  = (sel != 1);
            sd  = (sel != 0);
            a   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 65535));
            b   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            k   = ($urandom_range(0, 9) == 0) ? $urandom_range(3 + TIMEOUT, 60) : $urandom_range(3, 2 + TIMEOUT);
            do_op(sm, sd, a, b, rd, k, 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                chk("gap_stall", 32'(stall), 32'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
